// File: rtl/c1_pkg.sv
// rtl/c1_pkg.sv - shared stack-operation encoding and default sizes for the c1 core
package c1_pkg;

  typedef enum bit [2:0] {
    SHOLD    = 3'd0,
    SPUSH    = 3'd1,
    SPOP     = 3'd2,
    SREPL    = 3'd3,
    SPOPREPL = 3'd4
  } StackOp;

  localparam int DEPTH = 32;
  localparam int WIDTH = 64;

endpackage

// File: rtl/stack_ram.sv
// rtl/stack_ram.sv - spill array below T/S: one write port, one async read port, no reset
module stack_ram #(
  parameter int N     = 30,
  parameter int WIDTH = 64,
  parameter int PTRW  = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTRW-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTRW-1:0]  raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_stack.sv
// rtl/data_stack.sv - register-cached data stack: T/S in flops, deeper entries in stack_ram
module data_stack
  import c1_pkg::*;
#(
  parameter int DEPTH = c1_pkg::DEPTH,
  parameter int WIDTH = c1_pkg::WIDTH,
  parameter int PTRW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic             clear_err,
  output logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] s,
  output logic [PTRW:0]    depth,
  output logic             full,
  output logic             empty,
  output logic             ovf,
  output logic             unf
);

  localparam logic [PTRW:0]   DEPTH_C = (PTRW+1)'(DEPTH);
  localparam logic [PTRW:0]   D1      = (PTRW+1)'(1);
  localparam logic [PTRW:0]   D2      = (PTRW+1)'(2);
  localparam logic [PTRW:0]   D3      = (PTRW+1)'(3);
  localparam logic [PTRW-1:0] P1      = PTRW'(1);

  StackOp           op_e;
  logic [PTRW-1:0]  sp, sp_n, raddr;
  logic [WIDTH-1:0] t_n, s_n, rdata, s_below;
  logic [PTRW:0]    depth_n;
  logic             we, ovf_set, unf_set;

  assign op_e  = StackOp'(op);
  assign raddr = (sp == '0) ? '0 : sp - P1;
  // S refills from the spill array only while entries exist below it
  assign s_below = (depth >= D3) ? rdata : '0;

  stack_ram #(.N(DEPTH-2), .WIDTH(WIDTH), .PTRW(PTRW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (sp),
    .wdata (s),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    t_n     = t;
    s_n     = s;
    sp_n    = sp;
    depth_n = depth;
    we      = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (op_e)
      SPUSH: begin
        if (depth != DEPTH_C) begin
          t_n     = din;
          s_n     = t;
          depth_n = depth + D1;
          if (depth >= D2) begin
            we   = 1'b1;
            sp_n = sp + P1;
          end
        end else begin
          ovf_set = 1'b1;
        end
      end
      SPOP: begin
        if (depth >= D1) begin
          t_n     = s;
          s_n     = s_below;
          depth_n = depth - D1;
          if (depth >= D3) sp_n = sp - P1;
        end else begin
          unf_set = 1'b1;
        end
      end
      SREPL: begin
        if (depth >= D1) t_n = din;
        else unf_set = 1'b1;
      end
      SPOPREPL: begin
        if (depth >= D2) begin
          t_n     = din;
          s_n     = s_below;
          depth_n = depth - D1;
          if (depth >= D3) sp_n = sp - P1;
        end else begin
          unf_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t     <= '0;
      s     <= '0;
      sp    <= '0;
      depth <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      t     <= t_n;
      s     <= s_n;
      sp    <= sp_n;
      depth <= depth_n;
      ovf   <= ovf_set | (ovf & ~clear_err);
      unf   <= unf_set | (unf & ~clear_err);
    end
  end

  assign full  = (depth == DEPTH_C);
  assign empty = (depth == '0);

endmodule

// File: tb/tb_data_stack.sv
// tb/tb_data_stack.sv - scoreboard bench for data_stack with directed vectors
module tb_data_stack;

  localparam logic [2:0] HOLD = 3'd0, PUSH = 3'd1, POP = 3'd2, REPL = 3'd3, PREPL = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  op = HOLD;
  logic [63:0] din = '0;
  logic        clear_err = 1'b0;
  logic [63:0] t, s;
  logic [5:0]  depth;
  logic        full, empty, ovf, unf;

  typedef struct {
    logic [63:0] t;
    logic [63:0] s;
    logic [5:0]  depth;
    logic        ovf;
    logic        unf;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  data_stack dut (
    .clk(clk), .rst(rst), .op(op), .din(din), .clear_err(clear_err),
    .t(t), .s(s), .depth(depth), .full(full), .empty(empty), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [2:0] o, input logic [63:0] d, input logic c,
                      input logic [63:0] et, input logic [63:0] es, input int ed,
                      input logic eo, input logic eu, input string nm);
    exp_t e;
    @(negedge clk);
    op = o; din = d; clear_err = c;
    e.t = et; e.s = es; e.depth = 6'(ed); e.ovf = eo; e.unf = eu; e.name = nm;
    q.push_back(e);
  endtask

  // monitor: one expectation is consumed per edge after the stimulus was queued
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.name, ".t"}, t, e.t);
        chk({e.name, ".s"}, s, e.s);
        chk({e.name, ".depth"}, 64'(depth), 64'(e.depth));
        chk({e.name, ".full"}, 64'(full), 64'(e.depth == 6'd32));
        chk({e.name, ".empty"}, 64'(empty), 64'(e.depth == 6'd0));
        chk({e.name, ".ovf"}, 64'(ovf), 64'(e.ovf));
        chk({e.name, ".unf"}, 64'(unf), 64'(e.unf));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst.t", t, 0); chk("rst.s", s, 0); chk("rst.depth", 64'(depth), 0);
    chk("rst.empty", 64'(empty), 1); chk("rst.full", 64'(full), 0);
    chk("rst.ovf", 64'(ovf), 0); chk("rst.unf", 64'(unf), 0);
    @(negedge clk); rst = 1'b1;

    // basic push/pop
    step(PUSH, 64'h11, 0, 64'h11, 0, 1, 0, 0, "b_push1");
    step(PUSH, 64'h22, 0, 64'h22, 64'h11, 2, 0, 0, "b_push2");
    step(PUSH, 64'h33, 0, 64'h33, 64'h22, 3, 0, 0, "b_push3");
    step(POP, 0, 0, 64'h22, 64'h11, 2, 0, 0, "b_pop1");
    step(POP, 0, 0, 64'h11, 0, 1, 0, 0, "b_pop2");
    step(POP, 0, 0, 0, 0, 0, 0, 0, "b_pop3");

    // fill to capacity, overflow, drain
    for (int i = 1; i <= 32; i++)
      step(PUSH, 64'(i), 0, 64'(i), 64'(i - 1), i, 0, 0, "fill_push");
    step(PUSH, 64'hFF, 0, 64'd32, 64'd31, 32, 1, 0, "fill_ovf");
    for (int k = 1; k <= 32; k++)
      step(POP, 0, 0, 64'(32 - k), (32 - k >= 2) ? 64'(31 - k) : 64'd0, 32 - k, 1, 0, "drain_pop");
    step(HOLD, 0, 1, 0, 0, 0, 0, 0, "clr_ovf");

    // underflow and clear_err priority
    step(POP, 0, 0, 0, 0, 0, 0, 1, "unf_pop");
    step(POP, 0, 1, 0, 0, 0, 0, 1, "unf_setwins");
    step(HOLD, 0, 1, 0, 0, 0, 0, 0, "unf_clr");

    // pop-replace at shallow depth
    step(PUSH, 64'd5, 0, 64'd5, 0, 1, 0, 0, "pr_push5");
    step(PUSH, 64'd7, 0, 64'd7, 64'd5, 2, 0, 0, "pr_push7");
    step(PREPL, 64'd12, 0, 64'd12, 0, 1, 0, 0, "pr_ok");
    step(PREPL, 64'd13, 0, 64'd12, 0, 1, 0, 1, "pr_illegal");
    step(REPL, 64'd9, 0, 64'd9, 0, 1, 0, 1, "repl");
    step(HOLD, 0, 1, 64'd9, 0, 1, 0, 0, "pr_clr");
    step(POP, 0, 0, 0, 0, 0, 0, 0, "pr_pop");
    step(REPL, 64'd4, 0, 0, 0, 0, 0, 1, "repl_empty");
    step(HOLD, 0, 1, 0, 0, 0, 0, 0, "repl_clr");

    // spill read-back through pop-replace and pop
    step(PUSH, 64'd1, 0, 64'd1, 0, 1, 0, 0, "sp_push1");
    step(PUSH, 64'd2, 0, 64'd2, 64'd1, 2, 0, 0, "sp_push2");
    step(PUSH, 64'd3, 0, 64'd3, 64'd2, 3, 0, 0, "sp_push3");
    step(PUSH, 64'd4, 0, 64'd4, 64'd3, 4, 0, 0, "sp_push4");
    step(PREPL, 64'd7, 0, 64'd7, 64'd2, 3, 0, 0, "sp_prepl");
    step(POP, 0, 0, 64'd2, 64'd1, 2, 0, 0, "sp_pop");
    step(3'd5, 64'hDEAD, 0, 64'd2, 64'd1, 2, 0, 0, "op5_hold");
    step(3'd7, 64'hBEEF, 0, 64'd2, 64'd1, 2, 0, 0, "op7_hold");
    step(PUSH, 64'hA1, 0, 64'hA1, 64'd2, 3, 0, 0, "rs_push");

    // asynchronous reset between edges
    @(posedge clk);
    #3;
    op = HOLD;
    rst = 1'b0;
    #1;
    chk("arst.t", t, 0); chk("arst.s", s, 0); chk("arst.depth", 64'(depth), 0);
    chk("arst.empty", 64'(empty), 1); chk("arst.full", 64'(full), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step(PUSH, 64'hA, 0, 64'hA, 0, 1, 0, 0, "post_rst_push");

    @(negedge clk);
    op = HOLD;
    repeat (2) @(posedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_stack.md
# data_stack

Hardware data stack for the c1 stack core. Holds the top-of-stack (T) and second (S) in registers and spills deeper entries into a small register array, so the core's ALU stage reads T and S with zero latency and commits one stack operation per cycle. Sits directly beside the core's execute stage: the core drives `op`/`din` from its decoded instruction and ALU result, and consumes `t`, `s` and the status flags on the next cycle.

## Interface

- `DEPTH`, 32: total stack capacity in entries (T + S + spill array); must be ≥ 3.
- `WIDTH`, 64: data word width.
- `PTRW`, 5: spill pointer width, ≥ clog2(DEPTH-2).

- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst`  input  1  reset, asynchronous and active-low; one clock domain.
- `op`  input  3  stack operation, type `StackOp`.
- `din`  input  WIDTH  value pushed or written into T.
- `clear_err`  input  1  clears sticky `ovf`/`unf`.
- `t`  output  WIDTH  top of stack (registered).
- `s`  output  WIDTH  second entry (registered).
- `depth`  output  PTRW+1  number of valid entries, 0..DEPTH.
- `full`  output  1  `depth == DEPTH`.
- `empty`  output  1  `depth == 0`.
- `ovf`  output  1  sticky overflow flag.
- `unf`  output  1  sticky underflow flag.

## Operation

- `StackOp` encoding: SHOLD=0, SPUSH=1, SPOP=2, SREPL=3, SPOPREPL=4; codes 5–7 behave as SHOLD.
- SHOLD: no change.
- SPUSH: T←din, S←T, spill[sp]←S if depth≥2, sp+1 if depth≥2; depth+1.
- SPOP: T←S, S←spill[sp-1] if depth≥3 else 0, sp-1 if depth≥3; depth-1.
- SREPL: T←din; depth unchanged (unary ALU result).
- SPOPREPL: T←din, S←spill[sp-1] if depth≥3 else 0, sp-1 if depth≥3; depth-1 (binary ALU result).
- Legality: SPUSH requires depth<DEPTH; SPOP, SREPL require depth≥1; SPOPREPL requires depth≥2.
- Illegal op: no state changes at all (T, S, spill, sp, depth hold); `ovf` set for illegal SPUSH, `unf` for other illegal ops.
- Invariants: S reads 0 whenever depth<2; T reads 0 whenever depth=0 (SPOP from depth 1 loads T←S=0).
- sp = max(depth-2, 0) at all times; never wraps — bounds checks precede any pointer update.
- `clear_err` clears both flags; if an illegal op occurs in the same cycle, set wins for the flag it affects.
- `full`/`empty` are combinational decodes of registered `depth`.

## Timing

- Single-cycle: op sampled at edge N, new `t`/`s`/`depth`/flags visible after edge N; back-to-back ops every cycle, no stalls, no handshake.
- Spill read is combinational from the array at current `sp-1`; spill write occurs at the same edge as the push.
- Reset (asserted low, asynchronous): t=0, s=0, depth=0, sp=0, ovf=0, unf=0, hence empty=1, full=0. Spill array not reset (never read before written).
- Reset asserted mid-sequence discards all contents immediately; first op after deassertion sees an empty stack.

## Structure

- Shared package `c1_pkg`: `StackOp` enum (bit [2:0]), default `DEPTH`/`WIDTH` constants; the core imports the same enum for its decoder.
- Sub-module `stack_ram`: DEPTH-2 × WIDTH flop array, one write port, one async read port, no reset. Control, T/S registers, depth counter and flags stay in `data_stack`.

## Test plan

- Reset then SPUSH 0x11, 0x22, 0x33 → t=0x33, s=0x22, depth=3; SPOP ×3 → t/s sequence (0x22,0x11),(0x11,0),(0,0), depth 2,1,0, unf=0.
- Fill: 32 SPUSHes of values 1..32 → full=1, t=32, s=31; 33rd SPUSH 0xFF → t=32, depth=32, ovf=1; 32 SPOPs return 31..1 then 0 in T, empty=1.
- SPOP on empty → depth=0, t=0, unf=1; same cycle `clear_err`=1 → unf still 1; next cycle clear_err alone → unf=0.
- Push 5, 7; SPOPREPL din=12 → t=12, s=0, depth=1; SPOPREPL again → unchanged, unf=1; SREPL din=9 → t=9.
- Depth-3 spill: push 1,2,3,4; SPOPREPL din=7 → t=7, s=2, depth=3; SPOP → t=2, s=1.
- Push 3 values, assert rst mid-cycle between edges → outputs 0/empty immediately; after release SPUSH 0xA → t=0xA, s=0, depth=1.
